// File: rtl/fir_out_buffer.sv
// fir_out_buffer: FWFT output FIFO behind the FIR, drops samples when full (optional DROP_CNT via FIR_OBUF_DROPCNT_EN)
module fir_out_buffer #(
  parameter int NB    = 13,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  input  logic          RDY,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   LEVEL,
`ifdef FIR_OBUF_DROPCNT_EN
  output logic [7:0]    DROP_CNT,
`endif
  output logic          OVF
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [NB-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd, drop;
  assign FULL  = LEVEL == FULL_LVL;
  assign EMPTY = LEVEL == '0;
  assign VOUT  = ~EMPTY;
  assign DOUT  = VOUT ? mem[rd_ptr] : '0;
  assign rd    = VOUT & RDY;
  assign wr    = VIN & (~FULL | rd);
  assign drop  = VIN & ~wr;
  // sample storage, contents need no reset
  always_ff @(posedge CLK)
    if (wr) mem[wr_ptr] <= DIN;
  // pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge CLK)
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      LEVEL  <= LEVEL + (AW+1)'(wr) - (AW+1)'(rd);
    end
`ifdef FIR_OBUF_DROPCNT_EN
  // saturating count of dropped samples; overflow is any nonzero count
  always_ff @(posedge CLK)
    if (RST) DROP_CNT <= '0;
    else if (drop && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
  assign OVF = DROP_CNT != 8'd0;
`else
  logic ovf;
  // sticky overflow, cleared only by reset
  always_ff @(posedge CLK)
    if (RST) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  assign OVF = ovf;
`endif
endmodule

// File: tb/tb_fir_out_buffer.sv
// tb_fir_out_buffer: scoreboard bench for fir_out_buffer (covers DROP_CNT when FIR_OBUF_DROPCNT_EN is defined)
module tb_fir_out_buffer;
  localparam int NB = 13, DEPTH = 8, AW = 3;
  logic CLK = 0, RST = 1, VIN = 0, RDY = 0;
  logic [NB-1:0] DIN = '0;
  logic [NB-1:0] DOUT;
  logic VOUT, FULL, EMPTY, OVF;
  logic [AW:0] LEVEL;
`ifdef FIR_OBUF_DROPCNT_EN
  logic [7:0] DROP_CNT;
`endif
  int checks = 0, passed = 0;
  logic [NB-1:0] q [$];
  int lvl = 0, dcnt = 0;
  bit ovf = 0;
  fir_out_buffer #(.NB(NB), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .DOUT(DOUT), .VOUT(VOUT),
    .RDY(RDY), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
`ifdef FIR_OBUF_DROPCNT_EN
    .DROP_CNT(DROP_CNT),
`endif
    .OVF(OVF)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // model: compares registered state, then advances for the coming edge
  always @(negedge CLK) begin
    bit wr, rd;
    if (RST) begin
      q.delete();
      lvl = 0;
      ovf = 0;
      dcnt = 0;
    end else begin
      check("level", 32'(LEVEL), 32'(lvl));
      check("vout", 32'(VOUT), 32'(lvl != 0));
      check("empty", 32'(EMPTY), 32'(lvl == 0));
      check("full", 32'(FULL), 32'(lvl == DEPTH));
      check("ovf", 32'(OVF), 32'(ovf));
`ifdef FIR_OBUF_DROPCNT_EN
      check("drop_cnt", 32'(DROP_CNT), 32'(dcnt));
`endif
      check("dout", 32'(DOUT), lvl != 0 ? 32'(q[0]) : 32'd0);
      rd = lvl != 0 && RDY;
      if (rd) void'(q.pop_front());
      wr = VIN && (lvl != DEPTH || rd);
      if (VIN && !wr) begin
        ovf = 1;
        if (dcnt < 255) dcnt++;
      end
      if (wr) q.push_back(DIN);
      lvl = lvl + int'(wr) - int'(rd);
    end
  end
  task automatic cyc(input bit v, input logic [NB-1:0] d, input bit r);
    VIN = v;
    DIN = d;
    RDY = r;
    @(posedge CLK);
    #1;
  endtask
  task automatic reset_pulse(input bit v, input bit r);
    RST = 1;
    cyc(v, 13'h1555, r);
    RST = 0;
  endtask
  initial begin
    repeat (2) cyc(0, 0, 0);
    RST = 0;
    cyc(0, 0, 1);
    cyc(1, 13'h0001, 1);
    cyc(1, 13'h0002, 1);
    cyc(1, 13'h1FFF, 1);
    repeat (2) cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 13'(16 + i), 0);
    repeat (2) cyc(0, 0, 0);
    repeat (10) cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 13'(32 + i), 0);
    cyc(1, 13'h0AAA, 0);
    repeat (10) cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 13'(64 + i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 13'(128 + i), 1);
    repeat (3) cyc(0, 0, 0);
    reset_pulse(1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 13'(256 + i), 0);
    reset_pulse(1, 1);
    check("rst_level", 32'(LEVEL), 32'd0);
    check("rst_vout", 32'(VOUT), 32'd0);
    check("rst_ovf", 32'(OVF), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    cyc(1, 13'h0123, 0);
    cyc(1, 13'h0456, 1);
    repeat (4) cyc(0, 0, 1);
`ifdef FIR_OBUF_DROPCNT_EN
    for (int i = 0; i < 8; i++) cyc(1, 13'(512 + i), 0);
    for (int i = 0; i < 300; i++) cyc(1, 13'(i), 0);
    cyc(0, 0, 0);
    check("drop_sat", 32'(DROP_CNT), 32'd255);
    check("drop_ovf", 32'(OVF), 32'd1);
    reset_pulse(0, 0);
    check("drop_rst", 32'(DROP_CNT), 32'd0);
    cyc(0, 0, 0);
`endif
    check("drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
